// File: rtl/nandy_pkg.sv
// Shared definitions for the Nandy CPU fetch/execute sequencer.
// State encoding and the watchdog counter width.
package nandy_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      EXEC0 = 3'd1,
      EXEC1 = 3'd2,
      IRQ   = 3'd3,
      HALT  = 3'd4
   } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Single memory port shared by instruction fetch and EXEC1 data access.
// The sequencer is the master; the memory side answers with mem_rdy.
interface fetch_sequencer_if;

   logic mem_en;
   logic mem_is_data;
   logic mem_rdy;

   modport master (output mem_en, output mem_is_data, input mem_rdy);
   modport slave  (input mem_en, input mem_is_data, output mem_rdy);

endinterface

// File: rtl/stall_counter.sv
// Saturating memory-wait counter; terminal flags the last tolerated wait.
// Saturates at all-ones so a long stall can never wrap back to zero.
module stall_counter
   import nandy_pkg::*;
#(
   parameter int STALL_MAX = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count    = count_reg;
   assign terminal = (count_reg == CNT_W'(STALL_MAX));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer for the 8-bit Nandy CPU: phase bit, memory-port
// arbitration, interrupt enable/acknowledge and a stalled-bus watchdog.
module fetch_sequencer
   import nandy_pkg::*;
#(
   parameter int STALL_MAX = 15,
   parameter bit IE_RESET  = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   fetch_sequencer_if.master         mem,
   input  logic                      two_cycle,
   input  logic                      ie_set,
   input  logic                      ie_clr,
   input  logic                      irq,
   output logic                      cycle,
   output logic                      ir_load,
   output logic                      pc_inc,
   output logic                      exec_en,
   output logic                      irq_ack,
   output logic                      ie,
   output logic                      fault
);

   state_t           state_reg, state_next;
   logic             ie_reg, ie_next;
   logic             mem_en_c, mem_is_data_c;
   logic             stall_inc, stall_clr, stall_term;
   logic [CNT_W-1:0] stall_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= FETCH;
         ie_reg    <= IE_RESET;
      end else begin
         state_reg <= state_next;
         ie_reg    <= ie_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      ie_next       = ie_reg;
      cycle         = 1'b0;
      mem_en_c      = 1'b0;
      mem_is_data_c = 1'b0;
      ir_load       = 1'b0;
      pc_inc        = 1'b0;
      exec_en       = 1'b0;
      irq_ack       = 1'b0;
      fault         = 1'b0;
      case (state_reg)
         FETCH: begin
            // A zero count means this is the first FETCH cycle: the only
            // point an interrupt may be taken.
            if (irq && ie_reg && (stall_count == '0)) begin
               state_next = IRQ;
            end else begin
               mem_en_c = 1'b1;
               if (mem.mem_rdy) begin
                  ir_load    = 1'b1;
                  pc_inc     = 1'b1;
                  state_next = EXEC0;
               end else if (stall_term) begin
                  state_next = HALT;
               end
            end
         end
         EXEC0: begin
            exec_en = 1'b1;
            if (ie_clr) begin
               ie_next = 1'b0;
            end else if (ie_set) begin
               ie_next = 1'b1;
            end
            state_next = two_cycle ? EXEC1 : FETCH;
         end
         EXEC1: begin
            cycle         = 1'b1;
            mem_en_c      = 1'b1;
            mem_is_data_c = 1'b1;
            if (mem.mem_rdy) begin
               exec_en    = 1'b1;
               state_next = FETCH;
            end else if (stall_term) begin
               state_next = HALT;
            end
         end
         IRQ: begin
            irq_ack    = 1'b1;
            ie_next    = 1'b0;
            state_next = FETCH;
         end
         HALT: begin
            fault = 1'b1;
         end
         default: begin
            state_next = HALT;
         end
      endcase
      // State already sits at FETCH during reset; keep its strobes quiet.
      if (!rst_n) begin
         cycle         = 1'b0;
         mem_en_c      = 1'b0;
         mem_is_data_c = 1'b0;
         ir_load       = 1'b0;
         pc_inc        = 1'b0;
         exec_en       = 1'b0;
         irq_ack       = 1'b0;
         fault         = 1'b0;
      end
   end

   assign stall_inc = mem_en_c && !mem.mem_rdy;
   assign stall_clr = (mem_en_c && mem.mem_rdy) || (state_next != state_reg);

   stall_counter #(
      .STALL_MAX (STALL_MAX)
   ) u_stall (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (stall_inc),
      .clr      (stall_clr),
      .count    (stall_count),
      .terminal (stall_term)
   );

   assign mem.mem_en      = mem_en_c;
   assign mem.mem_is_data = mem_is_data_c;
   assign ie              = ie_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table plus hand sequences,
// expected outputs queued at drive time and compared mid-cycle.
module tb_fetch_sequencer;

   // inputs : {mem_rdy, two_cycle, ie_set, ie_clr, irq}
   // outputs: {cycle, mem_en, mem_is_data, ir_load, pc_inc, exec_en, irq_ack, ie, fault}
   typedef struct {
      string      name;
      logic [4:0] in;
      logic [8:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic two_cycle = 1'b0;
   logic ie_set = 1'b0;
   logic ie_clr = 1'b0;
   logic irq = 1'b0;
   logic cycle, ir_load, pc_inc, exec_en, irq_ack, ie, fault;
   logic [8:0] outs;

   int   checks = 0;
   int   errors = 0;
   vec_t sb[$];
   vec_t tbl [0:19];

   fetch_sequencer_if mif ();

   fetch_sequencer #(
      .STALL_MAX (15),
      .IE_RESET  (1'b0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem       (mif),
      .two_cycle (two_cycle),
      .ie_set    (ie_set),
      .ie_clr    (ie_clr),
      .irq       (irq),
      .cycle     (cycle),
      .ir_load   (ir_load),
      .pc_inc    (pc_inc),
      .exec_en   (exec_en),
      .irq_ack   (irq_ack),
      .ie        (ie),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   assign outs = {cycle, mif.mem_en, mif.mem_is_data, ir_load, pc_inc,
                  exec_en, irq_ack, ie, fault};

   task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %b want %b", nm, got, want);
      end
   endtask

   task automatic apply(input string nm, input logic [4:0] in, input logic [8:0] exp);
      vec_t v;
      {mif.mem_rdy, two_cycle, ie_set, ie_clr, irq} = in;
      v.name = nm;
      v.in   = in;
      v.exp  = exp;
      sb.push_back(v);
   endtask

   task automatic drive(input string nm, input logic [4:0] in, input logic [8:0] exp);
      @(posedge clk);
      #1;
      apply(nm, in, exp);
   endtask

   // Scoreboard: every cycle that was driven is compared mid-cycle.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         vec_t e;
         e = sb.pop_front();
         $display("txn %-10s in=%b out=%b", e.name, e.in, outs);
         chk(e.name, outs, e.exp);
      end
   end

   initial begin
      mif.mem_rdy = 1'b0;

      tbl[0]  = '{"f1",     5'b10000, 9'b010110000};
      tbl[1]  = '{"x1",     5'b10000, 9'b000001000};
      tbl[2]  = '{"f2",     5'b10000, 9'b010110000};
      tbl[3]  = '{"x2",     5'b10000, 9'b000001000};
      tbl[4]  = '{"f3",     5'b10000, 9'b010110000};
      tbl[5]  = '{"x3",     5'b10000, 9'b000001000};
      tbl[6]  = '{"f4",     5'b11000, 9'b010110000};
      tbl[7]  = '{"x4set",  5'b11100, 9'b000001000};
      tbl[8]  = '{"e4",     5'b10000, 9'b111001010};
      tbl[9]  = '{"f5",     5'b10000, 9'b010110010};
      tbl[10] = '{"x5both", 5'b10110, 9'b000001010};
      tbl[11] = '{"f6",     5'b10000, 9'b010110000};
      tbl[12] = '{"x6set",  5'b10100, 9'b000001000};
      tbl[13] = '{"firq",   5'b10001, 9'b000000010};
      tbl[14] = '{"ack",    5'b10001, 9'b000000110};
      tbl[15] = '{"f7",     5'b10001, 9'b010110000};
      tbl[16] = '{"x7",     5'b10001, 9'b000001000};
      tbl[17] = '{"fwait",  5'b00000, 9'b010000000};
      tbl[18] = '{"f8",     5'b10000, 9'b010110000};
      tbl[19] = '{"x8",     5'b11000, 9'b000001000};

      #3;
      chk("rst0", outs, 9'b000000000);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(tbl[0].name, tbl[0].in, tbl[0].exp);
      for (int i = 1; i < 20; i++) begin
         drive(tbl[i].name, tbl[i].in, tbl[i].exp);
      end

      // EXEC1: STALL_MAX waits, then mem_rdy on the terminal cycle wins.
      for (int i = 0; i < 15; i++) begin
         drive($sformatf("a_wait%0d", i), 5'b00000, 9'b111000000);
      end
      drive("a_rdy", 5'b10000, 9'b111001000);

      // Set ie, then abandon a stalled EXEC1 with an asynchronous reset.
      drive("c_fetch", 5'b10000, 9'b010110000);
      drive("c_x0set", 5'b11100, 9'b000001000);
      for (int i = 0; i < 4; i++) begin
         drive($sformatf("c_wait%0d", i), 5'b00000, 9'b111000010);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid", outs, 9'b000000000);

      // A cleared counter tolerates a full STALL_MAX of fetch waits.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply("b_fw0", 5'b00000, 9'b010000000);
      for (int i = 1; i < 15; i++) begin
         drive($sformatf("b_fw%0d", i), 5'b00000, 9'b010000000);
      end
      drive("b_fetch", 5'b10000, 9'b010110000);
      drive("b_x0", 5'b11000, 9'b000001000);
      for (int i = 0; i < 16; i++) begin
         drive($sformatf("b_wait%0d", i), 5'b00000, 9'b111000000);
      end
      for (int i = 0; i < 4; i++) begin
         drive($sformatf("halt%0d", i), 5'b10111, 9'b000000001);
      end

      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_halt", outs, 9'b000000000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply("z_fetch", 5'b10000, 9'b010110000);
      @(negedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got %0d want 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch and execute for the 8-bit Nandy CPU, and generates the `cycle` phase bit consumed by the combinational control decoder.
- Arbitrates the single memory port between instruction fetch and the second-cycle data access of memory-class instructions.
- Owns the interrupt-enable flag and the interrupt-acknowledge handshake.
- Owns a memory-stall watchdog that halts the CPU on a hung bus.

Parameters:
- STALL_MAX, 15: number of consecutive not-ready cycles tolerated in a memory-access state before a fault; legal range 1..255.
- IE_RESET, 0: value of the interrupt-enable flag after reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rdy  in  1  memory completes the current access this cycle.
- two_cycle  in  1  the latched instruction is memory-class, i.e. inst[7]; valid in EXEC0.
- ie_set  in  1  set interrupt enable; sampled in EXEC0.
- ie_clr  in  1  clear interrupt enable, driven from the decoder CLI; sampled in EXEC0.
- irq  in  1  level interrupt request.
- cycle  out  1  execute phase bit to the decoder: 0 in EXEC0, 1 in EXEC1.
- mem_en  out  1  memory port requested this cycle.
- mem_is_data  out  1  1 = data access (EXEC1), 0 = instruction fetch.
- ir_load  out  1  latch the instruction register this cycle.
- pc_inc  out  1  increment the PC this cycle.
- exec_en  out  1  the decoder's strobes (WA, WC, J, MW…) are committed this cycle.
- irq_ack  out  1  one-cycle interrupt acknowledge; the PC vector load is handled externally.
- ie  out  1  current interrupt-enable flag.
- fault  out  1  sticky watchdog fault.

Behaviour:
- Reset is asynchronous and active-low.
  - On reset: state = FETCH, ie = IE_RESET, stall counter = 0, fault = 0.
  - Every output except ie is 0 while rst_n is low.
  - Reset mid-access abandons the access; no ir_load or pc_inc is issued.
- The state register is encoded as FETCH, EXEC0, EXEC1, IRQ, HALT.
- FETCH
  - Outputs: mem_en = 1, mem_is_data = 0.
  - Entry check: if irq && ie on the first cycle in FETCH (stall counter = 0), go to IRQ without accessing memory.
  - Otherwise, when mem_rdy: ir_load = 1 and pc_inc = 1 (both Mealy, same cycle), then go to EXEC0.
- EXEC0
  - Outputs: cycle = 0, exec_en = 1; lasts exactly 1 cycle.
  - ie update: if ie_clr, ie becomes 0; else if ie_set, ie becomes 1. If both are asserted, clear wins.
  - Next state: EXEC1 if two_cycle, else FETCH.
- EXEC1
  - Outputs: cycle = 1, mem_en = 1, mem_is_data = 1.
  - exec_en = mem_rdy (Mealy).
  - When mem_rdy, go to FETCH. A jump taken here is loaded by the PC logic on the exec_en cycle.
- IRQ
  - Outputs: irq_ack = 1 for 1 cycle; ie is cleared in the same edge.
  - Next state: FETCH. The re-entry check then sees ie = 0, so no second acknowledge occurs.
- HALT
  - fault = 1; all other strobes are 0.
  - Exit only by reset.
- Watchdog (FETCH, EXEC1)
  - The counter increments on each cycle in which mem_en is asserted and mem_rdy = 0.
  - The counter clears when mem_rdy = 1 or the state changes.
  - If mem_rdy is still 0 when the counter equals STALL_MAX, go to HALT on that edge. STALL_MAX counted waits are allowed; the next wait faults.
  - mem_rdy arriving on that same cycle wins, and no fault occurs.
  - The counter saturates and does not wrap.
- Timing: a single-cycle instruction with zero-wait memory takes 2 clocks; a memory-class instruction takes 3.
- irq is sampled only at FETCH entry, never mid-instruction.
- mem_rdy outside FETCH and EXEC1 is ignored.

Decomposition:
- Shared package `nandy_pkg`:
  - state encoding constants (FETCH = 0, EXEC0 = 1, EXEC1 = 2, IRQ = 3, HALT = 4; 3-bit);
  - the counter width constant, 8.
- Sub-module `stall_counter`:
  - saturating up-counter with inc, clr and a terminal flag compared against STALL_MAX;
  - same asynchronous active-low reset.

Test Plan:
- Reset, then rst_n high, mem_rdy = 1, two_cycle = 0 → ir_load and pc_inc pulse at clocks 1, 3, 5; cycle stays 0; exec_en at clocks 2, 4, 6.
- two_cycle = 1, mem_rdy = 1 → per instruction FETCH, EXEC0 (cycle = 0), EXEC1 (cycle = 1, mem_is_data = 1), then back to FETCH; period 3 clocks.
- irq = 1 held, ie = 1 at FETCH entry → irq_ack for exactly one cycle and ie = 0 after; the following fetch proceeds normally with no second ack.
- ie_set and ie_clr both asserted in EXEC0 → ie = 0.
- mem_rdy = 0 for 15 cycles then 1 in EXEC1, with STALL_MAX = 15 → no fault, return to FETCH. mem_rdy held 0 for 16 cycles → fault = 1, HALT, and the outputs stay frozen until rst_n.
- rst_n pulsed low asynchronously mid-EXEC1 stall → outputs go to reset values immediately; after release the first fetch begins with the counter at 0.
